stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255, max cycles dmem_req may stay unacknowledged before the access is abandoned.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 EX  in  ex_out_t  upstream stage result with these fields:
- pc[31:0]
- res[31:0]: ALU result or effective address
- st_data[31:0]
- rd[4:0]
- w_rd
- mem_rd
- mem_wr
- mem_size[1:0]: 0 byte, 1 half, 2 word
- mem_sext
- bubble
REQ-006 out  out  mem_out_t  fields pc[31:0], res[31:0], rd[4:0], w_rd, bubble; consumed by writeback.
REQ-007 stall  out  1  upstream SHALL hold EX unchanged while high.
REQ-008 dmem_req / dmem_we  out  1 / 1  data-memory request and write enable.
REQ-009 dmem_addr  out  32  word address, bits [1:0] forced 0.
REQ-010 dmem_be / dmem_wdata  out  4 / 32  byte enables and store data.
REQ-011 dmem_ack / dmem_rdata  in  1 / 32  access complete and load data, valid in the ack cycle.
REQ-012 fault  out  1  one-cycle pulse on a misaligned access or bus timeout.

Function
REQ-013 Stage register SHALL capture all EX fields on a rising edge when stall=0, and SHALL hold them when stall=1.
REQ-014 The registered op is a memory op when !bubble && (mem_rd || mem_wr); mem_rd && mem_wr together SHALL be treated as a store.
REQ-015 Misaligned cases are half with addr[0]=1, and word with addr[1:0]≠0.
- A misaligned op SHALL issue no request and SHALL pulse fault for one cycle.
- It SHALL present out.bubble=1 and out.w_rd=0, with stall=0.
REQ-016 FSM states: IDLE and WAIT.
- An aligned memory op in IDLE SHALL assert dmem_req combinationally in the same cycle.
- If dmem_ack=0 in that cycle, the FSM SHALL go to WAIT.
- In WAIT, dmem_req SHALL stay high and all dmem_* outputs SHALL stay stable until ack.
- Ack SHALL return the FSM to IDLE.
REQ-017 stall SHALL be high iff an aligned memory op is registered and neither ack nor timeout occurs in the current cycle.
- Ack SHALL drop stall in the same cycle, so a zero-wait access costs zero extra cycles.
REQ-018 Byte lanes are little-endian, with o = addr[1:0]:
- Byte: be = 1<<o, wdata = st_data[7:0] replicated ×4.
- Half: be = 3<<o, wdata = st_data[15:0] replicated ×2.
- Word: be = 4'hF, wdata = st_data.
- Loads SHALL drive be = the same pattern and dmem_we=0.
REQ-019 Load result SHALL be (dmem_rdata >> 8*o), truncated to the access size, then sign- or zero-extended by mem_sext.
- out.res SHALL be valid combinationally in the ack cycle.
REQ-020 Non-memory ops SHALL pass the registered fields through.
- out.res = res.
- out.w_rd = w_rd && !bubble.
- stall = 0.
REQ-021 Stores SHALL force out.w_rd=0 and SHALL present out.bubble=0 in the ack cycle.
REQ-022 out.bubble SHALL be 1 whenever the registered op is a bubble, is misaligned, or is a memory op not completing this cycle.
- A pending op SHALL never reach writeback twice.
REQ-023 A wait counter SHALL count WAIT cycles and clear on ack or on entry to IDLE.
- When the count reaches BUS_TIMEOUT, the FSM SHALL return to IDLE, drop dmem_req, and pulse fault.
- A timed-out load SHALL complete with out.res=0 and out.w_rd as registered.
- A timed-out store SHALL complete with no effect.
REQ-024 If ack and timeout fall in the same cycle, ack SHALL win and fault SHALL stay 0.
REQ-025 The counter SHALL saturate and SHALL never wrap.
REQ-026 dmem_ack received while dmem_req=0 SHALL be ignored.

Reset
REQ-027 While rst is high, the following SHALL hold immediately and asynchronously:
- FSM=IDLE, counter=0.
- Registered bubble=1; other stage fields 0.
- out.bubble=1, out.w_rd=0.
- stall=0, dmem_req=0, fault=0.
REQ-028 Reset asserted mid-WAIT SHALL abandon the access with no fault, and the dropped op SHALL never appear at out.
REQ-029 After rst deasserts, the first non-bubble EX op SHALL be captured on the next rising edge.

Verification
REQ-030 Word load: addr 0x100, rdata=0xDEADBEEF, ack same cycle -> dmem_addr=0x100, be=F, stall=0, out.res=0xDEADBEEF, out.w_rd=1.
REQ-031 Signed byte load: addr 0x103, rdata=0x80FF1234, ack after 3 cycles -> be=8, stall high for 3 cycles with out.bubble=1, then out.res=0xFFFFFF80.
REQ-032 Half store: addr 0x202, st_data=0x0000ABCD -> be=C, wdata=0xABCDABCD, we=1, out.w_rd=0.
REQ-033 Misaligned word load at 0x101 -> no dmem_req, fault pulses once, out.bubble=1, stall=0.
REQ-034 Timeout with BUS_TIMEOUT=4 and no ack -> dmem_req high for exactly 4 cycles, then fault pulses, out.res=0, and the next EX op is accepted.
REQ-035 rst asserted during WAIT, with ack in the same cycle -> dmem_req drops immediately, out.bubble=1, fault=0, and no writeback of that op.

Source files
------------

// File: rtl/stage_mem_if.sv
// Payload types and the bundled bus between the memory stage, its upstream
// execute stage, writeback and the data memory.
package stage_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic        w_rd;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic        mem_sext;
        logic        bubble;
    } ex_out_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        w_rd;
        logic        bubble;
    } mem_out_t;

endpackage

interface stage_mem_if;
    import stage_mem_pkg::*;

    ex_out_t     ex;
    mem_out_t    out;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        fault;

    // master is the memory stage itself: it drives the data-memory request
    modport master (
        input  ex, dmem_ack, dmem_rdata,
        output out, stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, fault
    );

    modport slave (
        output ex, dmem_ack, dmem_rdata,
        input  out, stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, fault
    );

endinterface

// File: rtl/stage_mem.sv
// Pipeline memory stage: registers the EX result, issues aligned loads/stores
// to data memory with a bounded wait, and forwards the result to writeback.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    stage_mem_if.master   bus
);

    localparam int unsigned    CNT_W     = $clog2(BUS_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
    localparam ex_out_t        EX_RESET  = '{bubble: 1'b1, default: '0};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    ex_out_t          op;
    logic             fault_pulse;

    logic             is_mem;
    logic             is_store;
    logic             misaligned;
    logic             active;
    logic             acked;
    logic             timeout;
    logic             done;
    logic             hold;
    logic [1:0]       off;
    logic [CNT_W-1:0] waited;
    logic [31:0]      shifted;
    logic [31:0]      load_val;

    // Access decode, handshake resolution and lane steering
    always_comb begin
        off        = op.res[1:0];
        is_mem     = !op.bubble && (op.mem_rd || op.mem_wr);
        is_store   = op.mem_wr;
        misaligned = ((op.mem_size == SIZE_H) && off[0]) ||
                     (op.mem_size[1] && (off != 2'd0));
        active     = is_mem && !misaligned;
        // cnt already holds the unacknowledged request cycles before this one
        waited     = (state == S_WAIT) ? cnt : '0;
        acked      = active && bus.dmem_ack;
        timeout    = active && !bus.dmem_ack && (waited >= CNT_LIMIT);
        done       = acked || timeout;
        hold       = active && !done;

        shifted = bus.dmem_rdata >> {off, 3'b000};
        case (op.mem_size)
            SIZE_B:  load_val = {{24{op.mem_sext & shifted[7]}},  shifted[7:0]};
            SIZE_H:  load_val = {{16{op.mem_sext & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase

        bus.dmem_req  = active;
        bus.dmem_we   = active && is_store;
        bus.dmem_addr = {op.res[31:2], 2'b00};
        case (op.mem_size)
            SIZE_B: begin
                bus.dmem_be    = 4'b0001 << off;
                bus.dmem_wdata = {4{op.st_data[7:0]}};
            end
            SIZE_H: begin
                bus.dmem_be    = 4'b0011 << off;
                bus.dmem_wdata = {2{op.st_data[15:0]}};
            end
            default: begin
                bus.dmem_be    = 4'hF;
                bus.dmem_wdata = op.st_data;
            end
        endcase

        bus.stall = hold;
        bus.fault = fault_pulse;
    end

    // Writeback view: memory ops surface only in the cycle they complete
    always_comb begin
        bus.out.pc     = op.pc;
        bus.out.rd     = op.rd;
        bus.out.res    = op.res;
        bus.out.w_rd   = op.w_rd && !op.bubble;
        bus.out.bubble = op.bubble;
        if (is_mem) begin
            if (misaligned || !done) begin
                bus.out.bubble = 1'b1;
                bus.out.w_rd   = 1'b0;
            end else if (is_store) begin
                bus.out.bubble = 1'b0;
                bus.out.w_rd   = 1'b0;
            end else begin
                bus.out.bubble = 1'b0;
                bus.out.w_rd   = op.w_rd;
                bus.out.res    = acked ? load_val : '0;
            end
        end
    end

    // Stage register, wait FSM with saturating counter, and fault pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op          <= EX_RESET;
            state       <= S_IDLE;
            cnt         <= '0;
            fault_pulse <= 1'b0;
        end else begin
            if (!hold) begin
                op <= bus.ex;
            end
            fault_pulse <= (is_mem && misaligned) || timeout;
            if (hold) begin
                state <= S_WAIT;
                cnt   <= (waited == '1) ? waited : waited + CNT_W'(1);
            end else begin
                state <= S_IDLE;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Randomised scoreboard bench for stage_mem: a driver issues EX ops and queues
// expected memory transactions and writeback results; responder and monitor check them.
module tb_stage_mem;
    import stage_mem_pkg::*;

    localparam int unsigned TO = 4;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        w_rd;
    } out_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   ack_in_reset = 1'b0;

    mem_exp_t mem_q[$];
    out_exp_t out_q[$];
    int n_checks    = 0;
    int n_fail      = 0;
    int exp_faults  = 0;
    int seen_faults = 0;

    ex_out_t BUBBLE_OP;

    stage_mem_if bus();

    stage_mem #(.BUS_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Little-endian extract of a size-byte field at byte offset off, then extend
    function automatic logic [31:0] load_value(input logic [31:0] word, input int off,
                                               input int size, input bit sext);
        longint unsigned v;
        int bits;
        bits = 8 << size;
        v = longint'(word >> (8 * off)) & ((64'd1 << bits) - 1);
        if (sext && v >= (64'd1 << (bits - 1)))
            v = v - (64'd1 << bits);
        return 32'(v);
    endfunction

    task automatic run_op(input ex_out_t op, input int lat, input logic [31:0] rdata);
        bit       is_mem, mis, st, timed;
        int       off, exp_req, exp_stall, req_n, stall_n, cyc;
        mem_exp_t m;
        out_exp_t o;
        off    = int'(op.res[1:0]);
        is_mem = !op.bubble && (op.mem_rd || op.mem_wr);
        st     = op.mem_wr;
        mis    = (op.mem_size == 2'd1 && (off % 2) != 0) || (op.mem_size == 2'd2 && off != 0);
        timed  = lat >= int'(TO);
        exp_req   = 0;
        exp_stall = 0;
        o.pc = op.pc; o.rd = op.rd; o.res = op.res; o.w_rd = op.w_rd;
        if (op.bubble) begin
        end else if (!is_mem) begin
            out_q.push_back(o);
        end else if (mis) begin
            exp_faults++;
        end else begin
            m.lat   = lat;
            m.rdata = rdata;
            m.addr  = op.res & ~32'h3;
            m.we    = st;
            case (op.mem_size)
                2'd0: begin
                    m.be    = 4'(1 << off);
                    m.wdata = 32'(op.st_data[7:0]) * 32'h0101_0101;
                end
                2'd1: begin
                    m.be    = 4'(3 << off);
                    m.wdata = 32'(op.st_data[15:0]) * 32'h0001_0001;
                end
                default: begin
                    m.be    = 4'hF;
                    m.wdata = op.st_data;
                end
            endcase
            mem_q.push_back(m);
            exp_req   = timed ? int'(TO) : lat + 1;
            exp_stall = timed ? int'(TO) - 1 : lat;
            if (timed) exp_faults++;
            if (st)         o.w_rd = 1'b0;
            else if (timed) o.res  = '0;
            else            o.res  = load_value(rdata, off, int'(op.mem_size), op.mem_sext);
            out_q.push_back(o);
        end
        bus.ex = op;
        @(posedge clk);
        req_n = 0; stall_n = 0; cyc = 0;
        do begin
            @(negedge clk); #2;
            cyc++;
            if (bus.dmem_req) req_n++;
            if (bus.stall)    stall_n++;
        end while (bus.stall && cyc < 50);
        if (bus.stall) begin
            n_checks++; n_fail++;
            $display("FAIL stall_bound: stall still high after %0d cycles at %0t", cyc, $time);
        end
        bus.ex = BUBBLE_OP;
        chk("req_cycles",   32'(req_n),   32'(exp_req));
        chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
    endtask

    // Data-memory responder: acks after the queued latency, random ack when idle
    initial begin
        mem_exp_t cur;
        int age;
        age = 0;
        cur = '{lat: 0, rdata: 0, addr: 0, wdata: 0, be: 0, we: 0};
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.dmem_rdata = $urandom;
            if (rst) begin
                age = 0;
                bus.dmem_ack = ack_in_reset;
            end else if (bus.dmem_req) begin
                if (age == 0 && mem_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL spurious_req: addr 0x%08h requested with no access expected at %0t",
                             bus.dmem_addr, $time);
                    bus.dmem_ack = 1'b1;
                end else begin
                    if (age == 0) cur = mem_q.pop_front();
                    chk("dmem_addr",  bus.dmem_addr,        cur.addr);
                    chk("dmem_be",    32'(bus.dmem_be),     32'(cur.be));
                    chk("dmem_we",    32'(bus.dmem_we),     32'(cur.we));
                    if (cur.we) chk("dmem_wdata", bus.dmem_wdata, cur.wdata);
                    bus.dmem_ack = (age == cur.lat);
                    if (bus.dmem_ack) bus.dmem_rdata = cur.rdata;
                    age = (bus.dmem_ack || age + 1 >= int'(TO)) ? 0 : age + 1;
                end
            end else begin
                bus.dmem_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Writeback monitor: every non-bubble output must match the next expectation
    initial begin
        out_exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (bus.fault === 1'b1) seen_faults++;
                if (bus.out.bubble !== 1'b1) begin
                    if (out_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_wb: pc 0x%08h res 0x%08h reached writeback, nothing expected at %0t",
                                 bus.out.pc, bus.out.res, $time);
                    end else begin
                        e = out_q.pop_front();
                        chk("wb_pc",   bus.out.pc,          e.pc);
                        chk("wb_res",  bus.out.res,         e.res);
                        chk("wb_rd",   32'(bus.out.rd),     32'(e.rd));
                        chk("wb_w_rd", 32'(bus.out.w_rd),   32'(e.w_rd));
                    end
                end
            end
        end
    end

    initial begin
        ex_out_t op;
        int kind;
        BUBBLE_OP = '0;
        BUBBLE_OP.bubble = 1'b1;
        bus.ex = BUBBLE_OP;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_out_bubble", 32'(bus.out.bubble), 32'd1);
        chk("rst_out_w_rd",   32'(bus.out.w_rd),   32'd0);
        chk("rst_out_pc",     bus.out.pc,          32'd0);
        chk("rst_stall",      32'(bus.stall),      32'd0);
        chk("rst_req",        32'(bus.dmem_req),   32'd0);
        chk("rst_fault",      32'(bus.fault),      32'd0);
        rst = 1'b0;

        // word load, zero-wait
        op = '0; op.pc = 32'h1000; op.res = 32'h100; op.rd = 5'd5; op.w_rd = 1'b1;
        op.mem_rd = 1'b1; op.mem_size = 2'd2;
        run_op(op, 0, 32'hDEAD_BEEF);

        // signed byte load at top lane, three wait cycles
        op = '0; op.pc = 32'h1004; op.res = 32'h103; op.rd = 5'd6; op.w_rd = 1'b1;
        op.mem_rd = 1'b1; op.mem_size = 2'd0; op.mem_sext = 1'b1;
        run_op(op, 3, 32'h80FF_1234);

        // half store upper lanes
        op = '0; op.pc = 32'h1008; op.res = 32'h202; op.st_data = 32'h0000_ABCD;
        op.rd = 5'd7; op.w_rd = 1'b1; op.mem_wr = 1'b1; op.mem_size = 2'd1;
        run_op(op, 1, 32'h0);

        // misaligned word load
        op = '0; op.pc = 32'h100C; op.res = 32'h101; op.rd = 5'd8; op.w_rd = 1'b1;
        op.mem_rd = 1'b1; op.mem_size = 2'd2;
        run_op(op, 0, 32'h0);
        @(negedge clk); #2;
        chk("misalign_fault_pulse", 32'(bus.fault), 32'd1);
        @(negedge clk); #2;
        chk("misalign_fault_end",   32'(bus.fault), 32'd0);

        // bus timeout on a load
        op = '0; op.pc = 32'h1010; op.res = 32'h300; op.rd = 5'd9; op.w_rd = 1'b1;
        op.mem_rd = 1'b1; op.mem_size = 2'd2;
        run_op(op, 100, 32'h0);
        @(negedge clk); #2;
        chk("timeout_fault_pulse", 32'(bus.fault), 32'd1);
        @(negedge clk); #2;
        chk("timeout_fault_end",   32'(bus.fault), 32'd0);

        // ack in the last allowed cycle beats the timeout
        op = '0; op.pc = 32'h1014; op.res = 32'h304; op.rd = 5'd10; op.w_rd = 1'b1;
        op.mem_rd = 1'b1; op.mem_size = 2'd1;
        run_op(op, int'(TO) - 1, 32'h1234_8765);
        @(negedge clk); #2;
        chk("ack_wins_no_fault", 32'(bus.fault), 32'd0);

        // reset during WAIT with ack arriving in the same cycle
        op = '0; op.pc = 32'h1018; op.res = 32'h400; op.rd = 5'd11; op.w_rd = 1'b1;
        op.mem_rd = 1'b1; op.mem_size = 2'd2;
        mem_q.push_back('{lat: 2, rdata: 32'h5555_AAAA, addr: 32'h400, wdata: 32'h0,
                          be: 4'hF, we: 1'b0});
        bus.ex = op;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #3;
        ack_in_reset = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_wait_req_drop", 32'(bus.dmem_req), 32'd0);
        bus.ex = BUBBLE_OP;
        @(negedge clk); #2;
        chk("rst_wait_ack_seen",  32'(bus.dmem_ack),   32'd1);
        chk("rst_wait_bubble",    32'(bus.out.bubble), 32'd1);
        chk("rst_wait_w_rd",      32'(bus.out.w_rd),   32'd0);
        chk("rst_wait_fault",     32'(bus.fault),      32'd0);
        chk("rst_wait_stall",     32'(bus.stall),      32'd0);
        ack_in_reset = 1'b0;
        rst = 1'b0;

        // first op after reset is captured on the next edge
        op = '0; op.pc = 32'h2000; op.res = 32'hCAFE_F00D; op.rd = 5'd12; op.w_rd = 1'b1;
        run_op(op, 0, 32'h0);
        @(negedge clk); #2;
        chk("post_rst_fault", 32'(bus.fault), 32'd0);

        for (int i = 0; i < 300; i++) begin
            op = '0;
            op.pc       = $urandom;
            op.res      = $urandom;
            op.st_data  = $urandom;
            op.rd       = 5'($urandom);
            op.w_rd     = 1'($urandom);
            op.mem_size = 2'($urandom_range(0, 2));
            op.mem_sext = 1'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                op.bubble = 1'b1;
                op.mem_rd = 1'($urandom);
                op.mem_wr = 1'($urandom);
            end else if (kind >= 4 && kind <= 6) begin
                op.mem_rd = 1'b1;
            end else if (kind >= 7) begin
                op.mem_wr = 1'b1;
                op.mem_rd = 1'($urandom);
            end
            run_op(op, $urandom_range(0, 5), $urandom);
        end

        repeat (3) @(negedge clk);
        #2;
        chk("wb_pending",  32'(out_q.size()), 32'd0);
        chk("mem_pending", 32'(mem_q.size()), 32'd0);
        chk("fault_count", 32'(seen_faults),  32'(exp_faults));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
